// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and memory geometry.
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } imem_state_t;

    localparam int IMEM_BYTES  = 36;
    localparam int IMEM_ADDR_W = 6;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into big-endian byte memory while holding the core.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, core released
// LEN   | accepting word count N
// DATA  | accepting 4*N image bytes, one write each
// CSUM  | accepting XOR checksum byte (checksum build only)
// DONE  | load complete, done sticky
// ERR   | load aborted, error sticky
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    imem_state_t       state;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] last_idx;
    logic              xfer;
    logic [9:0]        total4;

    assign xfer   = in_valid && in_ready;
    // 10 bits so N=255 cannot wrap into a legal-looking size
    assign total4 = {in_data, 2'b00};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            counter  <= '0;
            last_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        if (in_data == 8'd0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else if (total4 > 10'(MEM_BYTES)) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state    <= DATA;
                            counter  <= '0;
                            last_idx <= ADDR_W'(total4 - 10'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum     <= in_data;
`endif
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= counter;
                        wr_data <= in_data;
                        counter <= counter + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum    <= csum ^ in_data;
                        if (counter == last_idx) begin
                            state <= CSUM;
                        end
`else
                        if (counter == last_idx) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        cpu_hold <= 1'b0;
                        if (in_data == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load cases, write scoreboard, reset-mid-load sequence.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       error;

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int n;
        int gaps;
        bit bad_csum;
        bit prog;
        bit exp_done;
        bit exp_err;
        int exp_writes;
    } vec_t;

    wr_t        sb[$];
    vec_t       vecs[7];
    logic [7:0] mem[64];
    logic [7:0] prog_bytes[16];
    int         checks = 0;
    int         failures = 0;
    int         wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    failures++;
                    $display("FAIL write actual=%0d:%0h required=%0d:%0h", wr_addr, wr_data, e.addr, e.data);
                end
                mem[wr_addr] = wr_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gaps, input bit poke_start);
        int t;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            start    = poke_start && (g == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout actual=%b required=1", in_ready);
        end
        check("cpu_hold_loading", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_case(input vec_t v);
        logic [7:0] b;
        logic [7:0] x;
        int         w0;
        w0 = wr_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 8'(v.n);
        send_byte(8'(v.n), 0, 1'b0);
        if (v.n > 0 && v.n * 4 <= 36) begin
            for (int i = 0; i < v.n * 4; i++) begin
                b = v.prog ? prog_bytes[i] : 8'($urandom_range(0, 255));
                x = x ^ b;
                sb.push_back('{addr: 6'(i), data: b});
                send_byte(b, (v.gaps > 0 && i % 2 == 1) ? v.gaps : 0, v.gaps > 0);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(v.bad_csum ? ~x : x, 0, 1'b0);
`endif
        end
        repeat (2) @(negedge clk);
        check("done", 32'(done), 32'(v.exp_done));
        check("error", 32'(error), 32'(v.exp_err));
        check("cpu_hold_end", 32'(cpu_hold), 32'd0);
        check("in_ready_end", 32'(in_ready), 32'd0);
        check("write_count", 32'(wr_count - w0), 32'(v.exp_writes));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        prog_bytes = '{8'hFC, 8'h22, 8'h18, 8'h21, 8'h1C, 8'h21, 8'h00, 8'h02,
                       8'h1C, 8'h43, 8'h00, 8'h02, 8'h78, 8'h23, 8'h00, 8'h01};
        //            n    gaps bad prog done err writes
        vecs[0] = '{4,   0, 0, 1, 1, 0, 16};
        vecs[1] = '{10,  0, 0, 0, 0, 1, 0};
        vecs[2] = '{9,   0, 0, 0, 1, 0, 36};
        vecs[3] = '{0,   0, 0, 0, 1, 0, 0};
        vecs[4] = '{2,   2, 0, 0, 1, 0, 8};
        vecs[5] = '{255, 0, 0, 0, 0, 1, 0};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[6] = '{1,   0, 1, 0, 0, 1, 4};
`else
        vecs[6] = '{1,   0, 1, 0, 1, 0, 4};
`endif

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_case(vecs[k]);
            if (k == 0)
                check("mem_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'hFC221821);
        end

        // Reset mid-load after 5 data bytes: outputs clear asynchronously.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'd4, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{addr: 6'(i), data: 8'(8'h40 + i)});
            send_byte(8'(8'h40 + i), 0, 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        check("async_cpu_hold", 32'(cpu_hold), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_wr_en", 32'(wr_en), 32'd0);
        check("async_wr_addr", 32'(wr_addr), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        check("mid_reset_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        run_case(vecs[0]);
        check("reload_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'hFC221821);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the byte-addressable, big-endian instruction memory.
- Accepts a program image as a byte stream over a valid/ready handshake and emits one registered byte write per accepted data byte. Stream byte k is written to address k, so the first byte is the MSB of word 0.
- Holds the core (cpu_hold) while loading. Reports done or error.

Parameters:
- MEM_BYTES, 36, instruction memory depth in bytes; must be a multiple of 4.
- ADDR_W, 6, width of wr_addr; must satisfy 2**ADDR_W >= MEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; accepted only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- wr_en  out  1  memory byte write strobe.
- wr_addr  out  ADDR_W  byte address to write.
- wr_data  out  8  byte to write.
- cpu_hold  out  1  core must stall or stay in reset.
- done  out  1  sticky; load completed successfully.
- error  out  1  sticky; load aborted.

Behaviour:
- Reset (async): state=IDLE; in_ready, wr_en, cpu_hold, done, error all 0; wr_addr=0; wr_data=0; byte counter=0.
- A byte transfer occurs on a rising edge where in_valid && in_ready are both high. in_ready is a registered, state-decoded signal and does not depend on in_valid.
- States:
  - IDLE: in_ready=0. On start go to LEN, set cpu_hold=1, clear done and error.
  - LEN: in_ready=1. The transferred byte is N, the word count.
    - N==0 -> DONE, no writes.
    - 4*N > MEM_BYTES -> ERR.
    - Otherwise latch total=4*N, counter=0, go to DATA.
  - DATA: in_ready=1. Each transferred byte produces wr_en=1, wr_addr=counter, wr_data=byte on the following cycle (latency 1, registered). Then counter++. When the byte with counter==total-1 is transferred, go to DONE (or CSUM, see Optional Feature).
  - DONE: in_ready=0, cpu_hold=0 in the same cycle the state is entered, done=1. The last write strobe is visible during the first DONE cycle.
  - ERR: in_ready=0, cpu_hold=0, error=1. No further writes.
- wr_en is a single-cycle pulse per accepted byte. It is never asserted in IDLE, LEN or ERR except as the trailing pulse from the final DATA byte.
- Arithmetic: N is 8 bits. Compute 4*N at 10 bits so that N=255 is correctly flagged as oversize. counter width is ADDR_W.
- Boundaries:
  - start while in LEN, DATA or CSUM is ignored.
  - start in DONE or ERR restarts the load and clears the sticky flags.
  - in_valid held low mid-stream causes the loader to wait indefinitely. There is no timeout.
  - The full image (4*N == MEM_BYTES) is legal and writes addresses 0..MEM_BYTES-1, with no wrap.
  - reset mid-load returns to IDLE immediately. Bytes already written stay in memory. cpu_hold drops.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, go to CSUM (in_ready=1) and accept one extra byte.
  - If it equals the XOR of N and all data bytes, go to DONE; otherwise go to ERR.
  - Writes already issued are not undone.
- Undefined: the CSUM state does not exist, and DATA goes directly to DONE.

Decomposition:
- Shared package imem_pkg:
  - state encoding constants: IDLE, LEN, DATA, CSUM, DONE, ERR;
  - IMEM_BYTES=36;
  - IMEM_ADDR_W=6.
- No sub-module is needed. The handshake and FSM are a single block, with the write register stage inline.

Test Plan:
- Program load: start; stream 04, FC 22 18 21, 1C 21 00 02, 1C 43 00 02, 78 23 00 01 -> 16 writes to addr 0..15 with matching bytes; done=1; cpu_hold=1 from start until DONE; memory word 0 reads FC221821.
- Oversize: stream 0A (40 bytes > 36) -> error=1, no wr_en pulses, in_ready=0.
- Full image and zero length:
  - N=09 -> 36 writes, last to addr 35.
  - N=00 -> done next cycle with 0 writes.
- Backpressure gaps: in_valid toggling 1-0-0-1 across data bytes -> writes occur only on transferred bytes, in order, addresses contiguous.
- Reset mid-load: assert reset after 5 data bytes -> all outputs 0 asynchronously, no further writes; a subsequent start reloads cleanly.
- Checksum (macro defined):
  - correct XOR byte -> done=1;
  - corrupted byte -> error=1, done=0.
